// File: rtl/des_pkg.sv
// Shared types and constants for the iterative (T)DES round sequencer.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [1:0] key_sel_t;

    localparam int ROUNDS_PER_PASS = 16;

    // Rounds whose C/D rotate is a single position (0, 1, 8, 15); all others rotate by two.
    localparam logic [15:0] SHIFT_ONE = 16'h8103;

endpackage

// File: rtl/des_round_ctrl_if.sv
// Block I/O handshake plus datapath/key-schedule control lines of the round sequencer.
interface des_round_ctrl_if;
    import des_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic       decrypt;
    logic       out_valid;
    logic       out_ready;
    logic       load;
    logic       chain;
    key_sel_t   key_sel;
    logic       round_en;
    logic [3:0] round_idx;
    logic [1:0] shift_amt;
    logic       shift_right;
    logic       last_round;
    logic       busy;

    // Requester / result consumer side.
    modport master (
        output in_valid, decrypt, out_ready,
        input  in_ready, out_valid, load, chain, key_sel, round_en,
               round_idx, shift_amt, shift_right, last_round, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, decrypt, out_ready,
        output in_ready, out_valid, load, chain, key_sel, round_en,
               round_idx, shift_amt, shift_right, last_round, busy
    );

endinterface

// File: rtl/des_shift_sched.sv
// C/D rotate amount for a round; decrypt-direction passes skip the rotate at round 0.
module des_shift_sched
    import des_pkg::*;
(
    input  logic [3:0] round_idx_i,
    input  logic       dir_dec_i,
    output logic [1:0] shift_amt_o
);

    // Decrypt direction starts from the un-rotated key, so round 0 does not move it.
    always_comb begin
        shift_amt_o = 2'd2;
        if (dir_dec_i && (round_idx_i == 4'd0))
            shift_amt_o = 2'd0;
        else if (SHIFT_ONE[round_idx_i])
            shift_amt_o = 2'd1;
    end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative (T)DES round sequencer: LOAD, 16 ROUND cycles per pass, EDE/DED key order.
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int NUM_PASSES = 3,
    parameter int ROUNDS     = ROUNDS_PER_PASS
) (
    input  logic              clk,
    input  logic              n_rst,
    des_round_ctrl_if.slave   bus
);

    localparam logic [1:0] LAST_PASS  = 2'(NUM_PASSES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    state_t     state_q, state_d;
    logic [1:0] pass_q, pass_d;
    logic [3:0] round_q, round_d;
    logic       dec_q, dec_d;

    logic       in_ready;
    logic       accept;
    logic       dir_dec;
    logic [1:0] shift_amt;
    key_sel_t   key_sel;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Pass 1 of a triple pass runs in the opposite direction to passes 0 and 2.
    assign dir_dec = dec_q ^ pass_q[0];

    // EDE uses K1,K2,K3 in order; DED walks the keys backwards. Single DES always uses K1.
    always_comb begin
        key_sel = pass_q;
        if (NUM_PASSES == 1)
            key_sel = 2'd0;
        else if (dec_q)
            key_sel = 2'd2 - pass_q;
    end

    des_shift_sched u_shift_sched (
        .round_idx_i (round_q),
        .dir_dec_i   (dir_dec),
        .shift_amt_o (shift_amt)
    );

    // State, pass and round registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            pass_q  <= 2'd0;
            round_q <= 4'd0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

    // Next-state: round counter restarts at every LOAD; an accept in DONE skips IDLE.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        round_d = round_q;
        dec_d   = dec_q;
        case (state_q)
            IDLE: ;
            LOAD: begin
                state_d = ROUND;
                round_d = 4'd0;
            end
            ROUND: begin
                if (round_q == LAST_ROUND) begin
                    round_d = 4'd0;
                    if (pass_q == LAST_PASS) begin
                        state_d = DONE;
                    end else begin
                        pass_d  = pass_q + 2'd1;
                        state_d = LOAD;
                    end
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = LOAD;
            pass_d  = 2'd0;
            dec_d   = bus.decrypt;
        end
    end

    // Control outputs, gated so IDLE/DONE present only the handshake lines.
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state_q == DONE);
    assign bus.load        = (state_q == LOAD);
    assign bus.chain       = (state_q == LOAD) && (pass_q != 2'd0);
    assign bus.key_sel     = ((state_q == LOAD) || (state_q == ROUND)) ? key_sel : 2'd0;
    assign bus.round_en    = (state_q == ROUND);
    assign bus.round_idx   = (state_q == ROUND) ? round_q : 4'd0;
    assign bus.shift_amt   = (state_q == ROUND) ? shift_amt : 2'd0;
    assign bus.shift_right = (state_q == ROUND) && dir_dec;
    assign bus.last_round  = (state_q == ROUND) && (round_q == LAST_ROUND);
    assign bus.busy        = (state_q != IDLE);

endmodule
